// File: rtl/mem_burst_control.sv
// Memory-stage burst sequencer: issues 1..MAX_BEATS beats per access and holds the upstream pipe with extend.
// Optional MEM_BURST_STALL_CNT_EN adds a saturating stall_cnt output of cycles with mem_req=1 and mem_ready=0.
module mem_burst_control #(
  parameter int unsigned MAX_BEATS = 4,
  parameter int unsigned OFF_W     = $clog2(MAX_BEATS),
  parameter int unsigned LEN_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             flush,
  input  logic [LEN_W-1:0] beats,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic [OFF_W-1:0] offset,
  output logic             extend,
  output logic             done,
  output logic             busy
`ifdef MEM_BURST_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state, state_nxt;
  logic [OFF_W-1:0] cnt, cnt_nxt;
  logic [OFF_W-1:0] last, last_nxt;
  logic [LEN_W-1:0] eff;
  logic             multi;

  // Normalise requested length to 1..MAX_BEATS
  always_comb begin
    if (beats == '0)
      eff = LEN_W'(1);
    else if (beats > LEN_W'(MAX_BEATS))
      eff = LEN_W'(MAX_BEATS);
    else
      eff = beats;
    multi = (eff > LEN_W'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  // Next state and zero-latency outputs; reset and flush force the outputs low
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    mem_req   = 1'b0;
    offset    = '0;
    extend    = 1'b0;
    done      = 1'b0;
    busy      = 1'b0;
    if (rst) begin
      busy = (state == BURST);
      if (flush) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (valid) begin
              mem_req = 1'b1;
              extend  = multi | ~mem_ready;
              done    = mem_ready & ~multi;
              if (mem_ready && multi) begin
                state_nxt = BURST;
                cnt_nxt   = OFF_W'(1);
                last_nxt  = OFF_W'(eff - LEN_W'(1));
              end
            end
          end
          BURST: begin
            mem_req = 1'b1;
            offset  = cnt;
            if (mem_ready) begin
              if (cnt == last) begin
                done      = 1'b1;
                state_nxt = IDLE;
                cnt_nxt   = '0;
              end else begin
                extend  = 1'b1;
                cnt_nxt = cnt + OFF_W'(1);
              end
            end else begin
              extend = 1'b1;
            end
          end
          default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        endcase
      end
    end
  end

`ifdef MEM_BURST_STALL_CNT_EN
  // Saturating count of cycles where memory held off a requested beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (mem_req && !mem_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mem_burst_control.sv
// Directed self-checking bench for mem_burst_control with MAX_BEATS=4.
module tb_mem_burst_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       flush;
  logic [2:0] beats;
  logic       mem_ready;
  logic       mem_req;
  logic [1:0] offset;
  logic       extend;
  logic       done;
  logic       busy;
`ifdef MEM_BURST_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mem_burst_control #(.MAX_BEATS(4)) dut (
    .clk(clk), .rst(rst), .valid(valid), .flush(flush), .beats(beats),
    .mem_ready(mem_ready), .mem_req(mem_req), .offset(offset),
    .extend(extend), .done(done), .busy(busy)
`ifdef MEM_BURST_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed vector: {mem_req, offset, extend, done, busy}
  task automatic test_reset();
    rst = 1'b0; valid = 1'b1; flush = 1'b0; beats = 3'd3; mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_req, offset, extend, done, busy} !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %b expected 000000", i, {mem_req, offset, extend, done, busy});
      end
      tick();
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, offset, extend, done, busy} !== 6'b1_00_100) begin
      errors++;
      $display("FAIL reset_release: got %b expected 100100", {mem_req, offset, extend, done, busy});
    end
    tick(); valid = 1'b0; #1;
    checks++;
    if ({mem_req, offset, extend, done, busy} !== 6'b1_01_101) begin
      errors++;
      $display("FAIL reset_beat1: got %b expected 101101", {mem_req, offset, extend, done, busy});
    end
    tick(); #1;
    checks++;
    if ({mem_req, offset, extend, done, busy} !== 6'b1_10_011) begin
      errors++;
      $display("FAIL reset_beat2: got %b expected 110011", {mem_req, offset, extend, done, busy});
    end
    tick(); #1;
    checks++;
    if ({mem_req, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: got %b expected 00", {mem_req, busy});
    end
  endtask

  // Four-beat burst with continuous ready; used for beats=4 and clamped beats=7
  task automatic test_burst(input logic [2:0] req_beats, input string tag);
    logic [1:0] eo [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic       ee [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       ed [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       eb [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    valid = 1'b1; beats = req_beats; mem_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({mem_req, offset, extend, done, busy} !== {1'b1, eo[i], ee[i], ed[i], eb[i]}) begin
        errors++;
        $display("FAIL %s_cycle%0d: got %b expected %b", tag, i,
                 {mem_req, offset, extend, done, busy}, {1'b1, eo[i], ee[i], ed[i], eb[i]});
      end
      tick();
      valid = 1'b0;
    end
    #1;
    checks++;
    if ({mem_req, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL %s_end: got %b expected 000", tag, {mem_req, busy, done});
    end
  endtask

  task automatic test_single();
    logic [2:0] bl [2] = '{3'd1, 3'd0};
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1; beats = bl[i]; mem_ready = 1'b1; flush = 1'b0;
      #1;
      checks++;
      if ({mem_req, offset, extend, done, busy} !== 6'b1_00_010) begin
        errors++;
        $display("FAIL single_beats%0d: got %b expected 100010", bl[i], {mem_req, offset, extend, done, busy});
      end
      tick(); valid = 1'b0; #1;
      checks++;
      if ({mem_req, busy} !== 2'b00) begin
        errors++;
        $display("FAIL single_idle_beats%0d: got %b expected 00", bl[i], {mem_req, busy});
      end
      tick();
    end
  endtask

  task automatic test_flush();
    valid = 1'b1; beats = 3'd4; mem_ready = 1'b1; flush = 1'b0;
    #1; tick(); valid = 1'b0; tick(); #1;
    checks++;
    if ({mem_req, offset, busy} !== 4'b1_10_1) begin
      errors++;
      $display("FAIL flush_pre: got %b expected 1101", {mem_req, offset, busy});
    end
    flush = 1'b1; #1;
    checks++;
    if ({mem_req, extend, done} !== 3'b000) begin
      errors++;
      $display("FAIL flush_same_cycle: got %b expected 000", {mem_req, extend, done});
    end
    tick(); flush = 1'b0; #1;
    checks++;
    if ({mem_req, busy} !== 2'b00) begin
      errors++;
      $display("FAIL flush_next: got %b expected 00", {mem_req, busy});
    end
    valid = 1'b1; beats = 3'd2; #1;
    checks++;
    if ({mem_req, offset, extend, done, busy} !== 6'b1_00_100) begin
      errors++;
      $display("FAIL flush_restart0: got %b expected 100100", {mem_req, offset, extend, done, busy});
    end
    tick(); valid = 1'b0; #1;
    checks++;
    if ({mem_req, offset, extend, done, busy} !== 6'b1_01_011) begin
      errors++;
      $display("FAIL flush_restart1: got %b expected 101011", {mem_req, offset, extend, done, busy});
    end
    tick();
    valid = 1'b1; flush = 1'b1; beats = 3'd1; #1;
    checks++;
    if ({mem_req, extend, done, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL flush_with_valid: got %b expected 0000", {mem_req, extend, done, busy});
    end
    tick(); valid = 1'b0; flush = 1'b0; #1;
    checks++;
    if ({mem_req, busy} !== 2'b00) begin
      errors++;
      $display("FAIL flush_with_valid_next: got %b expected 00", {mem_req, busy});
    end
  endtask

  task automatic test_reset_mid();
    valid = 1'b1; beats = 3'd4; mem_ready = 1'b1;
    #1; tick(); valid = 1'b0; #1;
    rst = 1'b0; #1;
    checks++;
    if ({mem_req, offset, extend, done, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid: got %b expected 000000", {mem_req, offset, extend, done, busy});
    end
    tick(); rst = 1'b1; #1;
    checks++;
    if ({mem_req, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_after: got %b expected 000", {mem_req, busy, done});
    end
  endtask

  task automatic test_stall();
    logic       rd [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] eo [5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    logic       ee [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       ed [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       eb [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    valid = 1'b1; beats = 3'd3; flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rd[i];
      #1;
      checks++;
      if ({mem_req, offset, extend, done, busy} !== {1'b1, eo[i], ee[i], ed[i], eb[i]}) begin
        errors++;
        $display("FAIL stall_cycle%0d: got %b expected %b", i,
                 {mem_req, offset, extend, done, busy}, {1'b1, eo[i], ee[i], ed[i], eb[i]});
      end
      tick();
      valid = 1'b0;
    end
    mem_ready = 1'b1; #1;
    checks++;
    if ({mem_req, busy} !== 2'b00) begin
      errors++;
      $display("FAIL stall_end: got %b expected 00", {mem_req, busy});
    end
`ifdef MEM_BURST_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd2) begin
      errors++;
      $display("FAIL stall_cnt: got %0d expected 2", stall_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    tick();
    test_burst(3'd4, "burst4");
    tick();
    test_single();
    test_burst(3'd7, "clamp7");
    tick();
    test_flush();
    tick();
    test_reset_mid();
    tick();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
